// File: rtl/fft_cbfp_align_buffer.sv
// Ping-pong delay buffer for the CBFP path: holds one group of beats while the zero
// counter settles, then replays it with a frozen per-beat count set and group exponent.
module fft_cbfp_align_buffer #(
  parameter  int din_size   = 23,
  parameter  int array_size = 16,
  parameter  int array_num  = 4,
  parameter  int cnt_size   = 5,
  localparam int IW         = $clog2(array_num)
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  clr,
  input  logic                                  valid_in,
  input  logic [array_size-1:0][din_size-1:0]   din_re,
  input  logic [array_size-1:0][din_size-1:0]   din_im,
  input  logic [array_num-1:0][cnt_size-1:0]    cal_cnt,
  output logic                                  valid_out,
  output logic [array_size-1:0][din_size-1:0]   dout_re,
  output logic [array_size-1:0][din_size-1:0]   dout_im,
  output logic [array_num-1:0][cnt_size-1:0]    cnt_hold,
  output logic [cnt_size-1:0]                   blk_exp,
  output logic [IW-1:0]                         beat_idx,
  output logic                                  grp_last
);

  // state | meaning
  // IDLE  | no group replaying; a latch edge emits beat 0 and moves to READ
  // READ  | replaying beats 1..array_num-1 of bank rd_bank
  typedef enum logic {IDLE, READ} state_t;

  localparam logic [IW-1:0] LAST = IW'(array_num - 1);

  typedef logic [array_size-1:0][din_size-1:0] beat_t;
  typedef logic [array_num-1:0][cnt_size-1:0]  cnts_t;

  beat_t mem_re_q [2][array_num];
  beat_t mem_im_q [2][array_num];

  state_t              state_q, state_d;
  logic [IW-1:0]       wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic                wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [1:0]          full_q, full_d;
  logic                latch_pend_q, latch_pend_d;
  logic                valid_q, valid_d, last_q, last_d;
  beat_t               dre_q, dre_d, dim_q, dim_d;
  logic [IW-1:0]       idx_q, idx_d;
  cnts_t               hold_q, hold_d;
  logic [cnt_size-1:0] exp_q, exp_d;
  logic                wr_en;

  function automatic logic [cnt_size-1:0] min_of(input cnts_t c);
    logic [cnt_size-1:0] m;
    m = c[0];
    for (int i = 1; i < array_num; i++)
      if (c[i] < m) m = c[i];
    return m;
  endfunction

  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    full_d       = full_q;
    latch_pend_d = 1'b0;
    valid_d      = 1'b0;
    last_d       = 1'b0;
    dre_d        = '0;
    dim_d        = '0;
    idx_d        = '0;
    hold_d       = hold_q;
    exp_d        = exp_q;
    wr_en        = 1'b0;
    if (clr) begin
      state_d  = IDLE;
      wr_cnt_d = '0;
      rd_cnt_d = '0;
      full_d   = '0;
    end else begin
      if (valid_in) begin
        wr_en = 1'b1;
        if (wr_cnt_q == LAST) begin
          wr_cnt_d          = '0;
          full_d[wr_bank_q] = 1'b1;
          latch_pend_d      = 1'b1;
          wr_bank_d         = ~wr_bank_q;
        end else begin
          wr_cnt_d = wr_cnt_q + 1'b1;
        end
      end
      // cal_cnt is complete one cycle after the final beat of a group
      if (latch_pend_q) begin
        hold_d = cal_cnt;
        exp_d  = min_of(cal_cnt);
      end
      if (state_q == READ || latch_pend_q) begin
        valid_d = 1'b1;
        dre_d   = mem_re_q[rd_bank_q][rd_cnt_q];
        dim_d   = mem_im_q[rd_bank_q][rd_cnt_q];
        idx_d   = rd_cnt_q;
        last_d  = (rd_cnt_q == LAST);
        if (rd_cnt_q == LAST) begin
          rd_cnt_d          = '0;
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = ~rd_bank_q;
          state_d           = latch_pend_q ? READ : IDLE;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
          state_d  = READ;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      full_q       <= '0;
      latch_pend_q <= 1'b0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      dre_q        <= '0;
      dim_q        <= '0;
      idx_q        <= '0;
      hold_q       <= '0;
      exp_q        <= '0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      full_q       <= full_d;
      latch_pend_q <= latch_pend_d;
      valid_q      <= valid_d;
      last_q       <= last_d;
      dre_q        <= dre_d;
      dim_q        <= dim_d;
      idx_q        <= idx_d;
      hold_q       <= hold_d;
      exp_q        <= exp_d;
    end
  end

  // Sample storage carries no reset; a bank is only read after being fully written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_re_q[wr_bank_q][wr_cnt_q] <= din_re;
      mem_im_q[wr_bank_q][wr_cnt_q] <= din_im;
    end
  end

  a_no_overwrite: assert property (@(posedge clk) disable iff (!rstn)
    (valid_in && !clr) |-> !full_q[wr_bank_q]);

  assign valid_out = valid_q;
  assign dout_re   = dre_q;
  assign dout_im   = dim_q;
  assign cnt_hold  = hold_q;
  assign blk_exp   = exp_q;
  assign beat_idx  = idx_q;
  assign grp_last  = last_q;

endmodule

// File: tb/tb_fft_cbfp_align_buffer.sv
// Directed bench for fft_cbfp_align_buffer: cycle table plus gapped-input and
// async-reset-during-readout sequences.
module tb_fft_cbfp_align_buffer;

  localparam int DW = 23, AS = 16, AN = 4, CW = 5;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic clr = 1'b0;
  logic valid_in = 1'b0;
  logic [AS-1:0][DW-1:0] din_re = '0, din_im = '0;
  logic [AN-1:0][CW-1:0] cal_cnt = '0;
  logic                  valid_out;
  logic [AS-1:0][DW-1:0] dout_re, dout_im;
  logic [AN-1:0][CW-1:0] cnt_hold;
  logic [CW-1:0]         blk_exp;
  logic [1:0]            beat_idx;
  logic                  grp_last;

  int n_cmp = 0;
  int n_err = 0;

  fft_cbfp_align_buffer #(.din_size(DW), .array_size(AS), .array_num(AN), .cnt_size(CW)) dut (
    .clk(clk), .rstn(rstn), .clr(clr), .valid_in(valid_in),
    .din_re(din_re), .din_im(din_im), .cal_cnt(cal_cnt),
    .valid_out(valid_out), .dout_re(dout_re), .dout_im(dout_im),
    .cnt_hold(cnt_hold), .blk_exp(blk_exp), .beat_idx(beat_idx), .grp_last(grp_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                  vin;
    logic                  clr;
    int                    tag;
    logic [AN-1:0][CW-1:0] cal;
    logic                  ev;
    int                    etag;
    logic [1:0]            eidx;
    logic                  elast;
    logic [AN-1:0][CW-1:0] ehold;
    logic [CW-1:0]         eexp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [AN-1:0][CW-1:0] pk(input int a, input int b, input int c, input int d);
    logic [AN-1:0][CW-1:0] r;
    r[0] = CW'(a); r[1] = CW'(b); r[2] = CW'(c); r[3] = CW'(d);
    return r;
  endfunction

  function automatic logic [AS-1:0][DW-1:0] mk_re(input int tag);
    logic [AS-1:0][DW-1:0] r;
    for (int k = 0; k < AS; k++) r[k] = DW'(tag * 16 + k);
    return r;
  endfunction

  function automatic logic [AS-1:0][DW-1:0] mk_im(input int tag);
    return ~mk_re(tag);
  endfunction

  task automatic add(input logic vin, input logic c, input int tag, input logic [AN-1:0][CW-1:0] cal,
                     input logic ev, input int etag, input int eidx, input logic elast,
                     input logic [AN-1:0][CW-1:0] ehold, input int eexp);
    vec_t v;
    v.vin = vin; v.clr = c; v.tag = tag; v.cal = cal;
    v.ev = ev; v.etag = etag; v.eidx = 2'(eidx); v.elast = elast;
    v.ehold = ehold; v.eexp = CW'(eexp);
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string nm, input logic ev, input int etag, input int eidx,
                           input logic elast, input logic [AN-1:0][CW-1:0] ehold, input int eexp);
    logic [AS-1:0][DW-1:0] xre, xim;
    xre = ev ? mk_re(etag) : '0;
    xim = ev ? mk_im(etag) : '0;
    chk({nm, ".valid_out"}, 512'(valid_out), 512'(ev));
    chk({nm, ".dout_re"},   512'(dout_re),   512'(xre));
    chk({nm, ".dout_im"},   512'(dout_im),   512'(xim));
    chk({nm, ".beat_idx"},  512'(beat_idx),  ev ? 512'(eidx) : 512'(0));
    chk({nm, ".grp_last"},  512'(grp_last),  ev ? 512'(elast) : 512'(0));
    chk({nm, ".cnt_hold"},  512'(cnt_hold),  512'(ehold));
    chk({nm, ".blk_exp"},   512'(blk_exp),   512'(eexp));
  endtask

  task automatic drive(input logic vin, input logic c, input int tag, input logic [AN-1:0][CW-1:0] cal);
    valid_in = vin;
    clr      = c;
    din_re   = mk_re(tag);
    din_im   = mk_im(tag);
    cal_cnt  = cal;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [AN-1:0][CW-1:0] H0, G0, GA, GB, GC, GD, GX, GF, GR1, GR2;
    H0 = pk(0, 0, 0, 0);    G0 = pk(3, 7, 2, 9);     GA = pk(4, 6, 5, 8);
    GB = pk(10, 12, 11, 13); GC = pk(17, 31, 16, 20); GD = pk(8, 5, 9, 6);
    GX = pk(1, 1, 1, 1);    GF = pk(31, 31, 31, 31); GR1 = pk(2, 3, 4, 5); GR2 = pk(1, 2, 3, 4);

    // reset held with busy inputs
    drive(1'b1, 1'b0, 5, GX);
    cyc(); cyc();
    check_all("rst_hold", 1'b0, 0, 0, 1'b0, H0, 0);
    drive(1'b0, 1'b0, 0, GX);
    rstn = 1'b1;
    cyc();
    check_all("rst_rel0", 1'b0, 0, 0, 1'b0, H0, 0);
    cyc();
    check_all("rst_rel1", 1'b0, 0, 0, 1'b0, H0, 0);

    // single group, counts {3,7,2,9} at the latch cycle
    for (int t = 0; t < 4; t++) add(1, 0, t, GX, 0, 0, 0, 0, H0, 0);
    add(0, 0, 0, G0, 1, 0, 0, 0, G0, 2);
    for (int t = 1; t < 4; t++) add(0, 0, 0, GX, 1, t, t, t == 3, G0, 2);
    add(0, 0, 0, GX, 0, 0, 0, 0, G0, 2);
    // back-to-back groups A (16..19), B (20..23), C (24..27)
    for (int t = 0; t < 4; t++) add(1, 0, 16 + t, GX, 0, 0, 0, 0, G0, 2);
    add(1, 0, 20, GA, 1, 16, 0, 0, GA, 4);
    add(1, 0, 21, GX, 1, 17, 1, 0, GA, 4);
    add(1, 0, 22, H0, 1, 18, 2, 0, GA, 4);
    add(1, 0, 23, GF, 1, 19, 3, 1, GA, 4);
    add(1, 0, 24, GB, 1, 20, 0, 0, GB, 10);
    add(1, 0, 25, GX, 1, 21, 1, 0, GB, 10);
    add(1, 0, 26, GF, 1, 22, 2, 0, GB, 10);
    add(1, 0, 27, GX, 1, 23, 3, 1, GB, 10);
    add(0, 0, 0, GC, 1, 24, 0, 0, GC, 16);
    for (int t = 1; t < 4; t++) add(0, 0, 0, GX, 1, 24 + t, t, t == 3, GC, 16);
    add(0, 0, 0, GX, 0, 0, 0, 0, GC, 16);
    // clr after two beats; the clr-cycle beat is dropped too
    add(1, 0, 40, GX, 0, 0, 0, 0, GC, 16);
    add(1, 0, 41, GX, 0, 0, 0, 0, GC, 16);
    add(1, 1, 42, GX, 0, 0, 0, 0, GC, 16);
    for (int t = 0; t < 4; t++) add(1, 0, 50 + t, GX, 0, 0, 0, 0, GC, 16);
    add(0, 0, 0, GD, 1, 50, 0, 0, GD, 5);
    for (int t = 1; t < 4; t++) add(0, 0, 0, GX, 1, 50 + t, t, t == 3, GD, 5);
    add(0, 0, 0, GX, 0, 0, 0, 0, GD, 5);

    foreach (tbl[i]) begin
      drive(tbl[i].vin, tbl[i].clr, tbl[i].tag, tbl[i].cal);
      cyc();
      check_all($sformatf("v%0d", i), tbl[i].ev, tbl[i].etag, int'(tbl[i].eidx),
                tbl[i].elast, tbl[i].ehold, int'(tbl[i].eexp));
    end

    // gapped replay of group A
    for (int b = 0; b < 4; b++) begin
      drive(1'b1, 1'b0, 16 + b, GX);
      cyc();
      check_all($sformatf("gap_b%0d", b), 1'b0, 0, 0, 1'b0, GD, 5);
      if (b < 3) begin
        int g;
        g = int'($urandom_range(1, 3));
        for (int j = 0; j < g; j++) begin
          drive(1'b0, 1'b0, 0, GX);
          cyc();
          check_all($sformatf("gap_b%0d_idle%0d", b, j), 1'b0, 0, 0, 1'b0, GD, 5);
        end
      end
    end
    drive(1'b0, 1'b0, 0, GA);
    cyc();
    check_all("gap_r0", 1'b1, 16, 0, 1'b0, GA, 4);
    drive(1'b0, 1'b0, 0, GX);
    for (int t = 1; t < 4; t++) begin
      cyc();
      check_all($sformatf("gap_r%0d", t), 1'b1, 16 + t, t, t == 3, GA, 4);
    end
    cyc();
    check_all("gap_end", 1'b0, 0, 0, 1'b0, GA, 4);

    // async reset during readout beat 1
    for (int t = 0; t < 4; t++) begin
      drive(1'b1, 1'b0, 60 + t, GX);
      cyc();
    end
    drive(1'b0, 1'b0, 0, GR1);
    cyc();
    check_all("ar_r0", 1'b1, 60, 0, 1'b0, GR1, 2);
    drive(1'b0, 1'b0, 0, GX);
    cyc();
    check_all("ar_r1", 1'b1, 61, 1, 1'b0, GR1, 2);
    #2 rstn = 1'b0;
    #1 check_all("ar_async", 1'b0, 0, 0, 1'b0, H0, 0);
    cyc();
    rstn = 1'b1;
    for (int j = 0; j < 3; j++) begin
      cyc();
      check_all($sformatf("ar_idle%0d", j), 1'b0, 0, 0, 1'b0, H0, 0);
    end
    for (int t = 0; t < 4; t++) begin
      drive(1'b1, 1'b0, 70 + t, GX);
      cyc();
      check_all($sformatf("ar_w%0d", t), 1'b0, 0, 0, 1'b0, H0, 0);
    end
    drive(1'b0, 1'b0, 0, GR2);
    cyc();
    check_all("ar_n0", 1'b1, 70, 0, 1'b0, GR2, 1);
    drive(1'b0, 1'b0, 0, GX);
    for (int t = 1; t < 4; t++) begin
      cyc();
      check_all($sformatf("ar_n%0d", t), 1'b1, 70 + t, t, t == 3, GR2, 1);
    end
    cyc();
    check_all("ar_end", 1'b0, 0, 0, 1'b0, GR2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
